// File: rtl/seg_scan_decoder.sv
// Recovers minutes, seconds and two team scores from a scanned 8-digit
// seven-segment display by sampling each digit once its drive has settled.
`timescale 1ns/1ps

module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] Anode_Activate,
  input  logic [6:0] LED_out,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic [6:0] team_1,
  output logic [6:0] team_2,
  output logic       frame_valid,
  output logic       pattern_error,
  output logic       anode_error
);

  localparam logic [15:0] CNT_LAST = 16'(SETTLE_CYCLES - 1);

  logic [7:0]  an_q, an_p;
  logic [6:0]  led_q, led_p;
  logic [15:0] cnt;
  logic        armed;
  logic [7:0]  seen;
  logic [3:0]  slot [8];

  logic        changed;
  logic        capture;
  logic [7:0]  low;
  logic        one_low;
  logic        multi_low;
  logic [2:0]  idx;
  logic        dig_ok;
  logic [3:0]  dig_val;
  logic        frame_done;
  logic [7:0]  seen_base;

  function automatic logic [6:0] join_digits(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

  assign changed    = (an_q != an_p) || (led_q != led_p);
  // armed drops after a capture so a long dwell yields exactly one sample
  assign capture    = !changed && armed && (cnt == CNT_LAST);
  assign low        = ~an_q;
  assign one_low    = (low != 8'h00) && ((low & (low - 8'd1)) == 8'h00);
  assign multi_low  = (low != 8'h00) && !one_low;
  assign frame_done = (seen == 8'hFF);
  assign seen_base  = frame_done ? 8'h00 : seen;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (low[i]) idx = 3'(i);
    end
  end

  // Active-low cathodes, bit 6 = segment a
  always_comb begin
    dig_ok  = 1'b1;
    dig_val = 4'd0;
    case (led_q)
      7'b0000001: dig_val = 4'd0;
      7'b1001111: dig_val = 4'd1;
      7'b0010010: dig_val = 4'd2;
      7'b0000110: dig_val = 4'd3;
      7'b1001100: dig_val = 4'd4;
      7'b0100100: dig_val = 4'd5;
      7'b0100000: dig_val = 4'd6;
      7'b0001111: dig_val = 4'd7;
      7'b0000000: dig_val = 4'd8;
      7'b0000100: dig_val = 4'd9;
      default:    dig_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an_q  <= 8'hFF;
      an_p  <= 8'hFF;
      led_q <= 7'h7F;
      led_p <= 7'h7F;
      cnt   <= 16'd0;
      armed <= 1'b1;
    end else begin
      an_q  <= Anode_Activate;
      an_p  <= an_q;
      led_q <= LED_out;
      led_p <= led_q;
      if (changed) begin
        cnt   <= 16'd0;
        armed <= 1'b1;
      end else if (capture) begin
        armed <= 1'b0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen          <= 8'h00;
      pattern_error <= 1'b0;
      anode_error   <= 1'b0;
      for (int i = 0; i < 8; i++) slot[i] <= 4'd0;
    end else begin
      pattern_error <= capture && one_low && !dig_ok;
      anode_error   <= capture && multi_low;
      // A completed set is cleared in the same cycle a new capture may land
      if (capture && one_low) begin
        if (dig_ok) begin
          slot[idx] <= dig_val;
          seen      <= seen_base | (8'h01 << idx);
        end else begin
          seen      <= seen_base & ~(8'h01 << idx);
        end
      end else begin
        seen <= seen_base;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      minutes     <= 7'd0;
      seconds     <= 7'd0;
      team_1      <= 7'd0;
      team_2      <= 7'd0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        minutes <= join_digits(slot[0], slot[1]);
        seconds <= join_digits(slot[2], slot[3]);
        team_2  <= join_digits(slot[4], slot[5]);
        team_1  <= join_digits(slot[6], slot[7]);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digit sets through the display
// inputs and compares decoded values, pulse counts and frame latency.
`timescale 1ns/1ps

module tb_seg_scan_decoder;

  localparam int S     = 32;
  localparam int DWELL = 64;

  // clock / reset
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] anode = 8'hFF;
  logic [6:0] led   = 7'h7F;
  logic [6:0] minutes, seconds, team_1, team_2;
  logic       frame_valid, pattern_error, anode_error;

  always #5 clock = ~clock;

  seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clock          (clock),
    .reset          (reset),
    .Anode_Activate (anode),
    .LED_out        (led),
    .minutes        (minutes),
    .seconds        (seconds),
    .team_1         (team_1),
    .team_2         (team_2),
    .frame_valid    (frame_valid),
    .pattern_error  (pattern_error),
    .anode_error    (anode_error)
  );

  int cyc = 0;
  int fv_cnt = 0, pe_cnt = 0, ae_cnt = 0;
  int fv_cyc = 0;
  int last_start = 0;
  int n_checks = 0, n_pass = 0;

  always @(posedge clock) cyc++;

  // pulses are counted per high cycle, so a stretched pulse shows as an extra count
  always @(negedge clock) begin
    if (reset) begin
      if (frame_valid) begin
        fv_cnt++;
        fv_cyc = cyc;
      end
      if (pattern_error) pe_cnt++;
      if (anode_error) ae_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // driver tasks
  task automatic show(input logic [7:0] an, input logic [6:0] pat, input int n);
    @(negedge clock);
    anode = an;
    led = pat;
    last_start = cyc;
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic scan_range(input logic [31:0] dg, input int first, input int last,
                            input int short_idx, input int short_len, input int bad_idx);
    for (int i = first; i <= last; i++) begin
      logic [7:0] an;
      an = ~(8'h01 << i);
      show(an, (i == bad_idx) ? 7'h7F : seg(dg[4*i +: 4]), (i == short_idx) ? short_len : DWELL);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    anode = 8'hFF;
    led = 7'h7F;
    #1;
    check({tag, "_min"}, minutes, 0);
    check({tag, "_sec"}, seconds, 0);
    check({tag, "_t1"}, team_1, 0);
    check({tag, "_t2"}, team_2, 0);
    check({tag, "_fv"}, frame_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic check_vals(input string tag, input int m, input int s, input int t1, input int t2);
    check({tag, "_min"}, minutes, m);
    check({tag, "_sec"}, seconds, s);
    check({tag, "_t1"}, team_1, t1);
    check({tag, "_t2"}, team_2, t2);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_min", minutes, 0);
    check("rst_sec", seconds, 0);
    check("rst_t1", team_1, 0);
    check("rst_t2", team_2, 0);
    check("rst_pe", pattern_error, 0);
    check("rst_ae", anode_error, 0);
    reset = 1'b1;

    // 12:00, team_2 45, team_1 07
    scan_range(32'h70540021, 0, 7, -1, 0, -1);
    check("scan1_latency", fv_cyc - last_start - 1, S + 2);
    show(8'hFF, 7'h7F, DWELL);
    check("scan1_fv", fv_cnt, 1);
    check_vals("scan1", 12, 0, 7, 45);

    // digit 3 dwell too short: no frame until the following full scan
    scan_range(32'h09876543, 0, 7, 3, 16, -1);
    check("short_fv", fv_cnt, 1);
    check_vals("short_hold", 12, 0, 7, 45);
    scan_range(32'h09876543, 0, 7, -1, 0, -1);
    check("short_next_fv", fv_cnt, 2);
    check_vals("scan2", 34, 56, 90, 78);

    // illegal cathode pattern on digit 5, then a legal recapture
    do_reset("rst2");
    scan_range(32'h76543210, 0, 7, -1, 0, 5);
    check("pat_pe", pe_cnt, 1);
    check("pat_fv", fv_cnt, 2);
    check_vals("pat_hold", 0, 0, 0, 0);
    show(8'hDF, seg(4'd5), DWELL);
    check("pat_fix_fv", fv_cnt, 3);
    check_vals("pat_fix", 1, 23, 67, 45);

    // two anodes low, then a blank dwell
    show(8'hFC, seg(4'd3), DWELL);
    check("anode_ae", ae_cnt, 1);
    check("anode_fv", fv_cnt, 3);
    check_vals("anode_hold", 1, 23, 67, 45);
    show(8'hFF, seg(4'd8), DWELL);
    check("blank_ae", ae_cnt, 1);
    check("blank_pe", pe_cnt, 1);

    // reset after five digits discards them
    scan_range(32'h44332218, 0, 4, -1, 0, -1);
    do_reset("rst3");
    scan_range(32'h44332218, 5, 7, -1, 0, -1);
    check("partial_fv", fv_cnt, 3);
    check_vals("partial_hold", 0, 0, 0, 0);
    show(8'hFE, seg(4'd9), DWELL);
    scan_range(32'h44332218, 0, 7, -1, 0, -1);
    check("overwrite_fv", fv_cnt, 4);
    check_vals("overwrite", 81, 22, 44, 33);

    // cathode toggling faster than the settle window on digit 7
    do_reset("rst4");
    scan_range(32'h86321095, 0, 6, -1, 0, -1);
    for (int k = 0; k < 5; k++) show(8'h7F, seg((k % 2) ? 4'd3 : 4'd8), 20);
    check("toggle_fv", fv_cnt, 4);
    show(8'h7F, seg(4'd8), DWELL);
    check("toggle_done_fv", fv_cnt, 5);
    check_vals("toggle", 59, 1, 68, 23);

    check("total_pe", pe_cnt, 1);
    check("total_ae", ae_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1024, the number of consecutive cycles that Anode_Activate and LED_out must hold unchanged before a digit is captured (legal 2..65535).
REQ-002 Port clock, input, 1, the 100 MHz system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-low reset.
REQ-004 Port Anode_Activate, input, 8, scanned anode enables, active-low, bit n selects digit n.
REQ-005 Port LED_out, input, 7, cathode pattern, active-low, bit 6 = segment a through bit 0 = segment g.
REQ-006 Port minutes, output, 7, decoded clock minutes, 0..99.
REQ-007 Port seconds, output, 7, decoded clock seconds, 0..99.
REQ-008 Port team_1, output, 7, decoded team 1 score, 0..99.
REQ-009 Port team_2, output, 7, decoded team 2 score, 0..99.
REQ-010 Port frame_valid, output, 1, one-cycle pulse when all four values update.
REQ-011 Port pattern_error, output, 1, one-cycle pulse when a settled cathode pattern is not a legal digit.
REQ-012 Port anode_error, output, 1, one-cycle pulse when a settled anode word has more than one bit low.

Function
REQ-013 Digit map SHALL be: bit0 minutes tens, bit1 minutes ones, bit2 seconds tens, bit3 seconds ones, bit4 team_2 tens, bit5 team_2 ones, bit6 team_1 tens, bit7 team_1 ones.
REQ-014 Cathode decode SHALL be exactly: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; every other pattern is illegal.
REQ-015 The block SHALL register both inputs once; a settle counter resets to 0 on any change of either registered input versus its previous registered value, else increments, saturating at SETTLE_CYCLES-1.
REQ-016 Capture SHALL occur exactly once per dwell: on the cycle the counter first reaches SETTLE_CYCLES-1; no further capture until an input changes.
REQ-017 At capture with exactly one anode bit low and a legal pattern: decoded digit stored in shadow slot n, seen[n] set.
REQ-018 At capture with exactly one anode bit low and an illegal pattern: pattern_error pulses next cycle, seen[n] cleared, slot n unchanged.
REQ-019 At capture with two or more anode bits low: anode_error pulses next cycle, no slot or seen bit changes.
REQ-020 At capture with Anode_Activate = 8'hFF (blank): no action, no error.
REQ-021 When seen becomes 8'hFF, the next cycle SHALL load minutes/seconds/team_1/team_2 = tens*10 + ones from shadow slots, pulse frame_valid, and clear seen to 0.
REQ-022 Outputs SHALL hold between frame_valid pulses; a partial frame never alters outputs.
REQ-023 Recapture of an already-seen slot before frame completion SHALL overwrite that slot (latest value wins).
REQ-024 frame_valid and an error pulse MAY coincide only if caused by different captures; each pulse is exactly one cycle.
REQ-025 Total latency from start of the settled 8th digit to frame_valid SHALL be SETTLE_CYCLES+2 cycles.

Reset
REQ-026 reset low SHALL immediately clear minutes, seconds, team_1, team_2, frame_valid, pattern_error, anode_error, settle counter, seen mask and shadow slots to 0.
REQ-027 Reset asserted mid-frame SHALL discard all partial digits; after release a full new set of 8 captures is required before frame_valid.
REQ-028 First capture after release SHALL require a full SETTLE_CYCLES dwell.

Verification
REQ-029 Scan 12:00, team_2=45, team_1=07, 2000 cycles per digit, SETTLE_CYCLES=1024 -> one frame_valid after digit 7; minutes=12, seconds=0, team_2=45, team_1=7.
REQ-030 Digit 3 dwell of 500 cycles only, rest normal -> no frame_valid in that scan; next full scan produces frame.
REQ-031 Digit 5 LED_out=1111111 settled -> pattern_error one cycle, no frame_valid until a later legal capture of digit 5 completes the set.
REQ-032 Anode_Activate=11111100 settled -> anode_error one cycle; outputs unchanged.
REQ-033 Reset pulsed after 5 digits captured -> outputs 0; 3 further digits alone produce no frame_valid.
REQ-034 LED_out toggles every 700 cycles within one anode dwell of 3000 -> no capture during that dwell.
